bit_string_printer: RTL and testbench

//  Encoder side of the keyboard bit-entry path: takes 8-bit values and prints each
//  as ASCII '0'/'1' characters (plus optional CR LF) on the UART transmitter interface.

---
 rtl/bit_string_printer.sv | 134 +++++++++++++
 tb/tb_bit_string_printer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bit_string_printer.sv
// Prints each queued byte as eight ASCII '0'/'1' characters (plus optional CR LF)
// on a UART transmitter strobe interface, behind a small input FIFO.
module bit_string_printer #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ADDR_W     = 2,
  parameter int unsigned SEND_CRLF  = 1,
  parameter int unsigned MSB_FIRST  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [7:0]        i_in_data,
  input  logic              i_in_valid,
  output logic              o_in_ready,
  output logic              o_overflow,
  output logic [7:0]        o_tx_data,
  output logic              o_new_tx_data,
  input  logic              i_tx_busy,
  output logic              o_busy,
  output logic [ADDR_W:0]   o_fifo_count
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(FIFO_DEPTH);
  localparam logic [3:0]      LP_LAST  = (SEND_CRLF != 0) ? 4'd9 : 4'd7;

  typedef enum logic [1:0] {StIdle, StSend, StGap} state_t;

  logic [7:0]        r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wptr, r_rptr;
  logic [ADDR_W:0]   r_count;

  state_t     r_state, w_state_d;
  logic [7:0] r_shift, w_shift_d;
  logic [3:0] r_idx, w_idx_d;
  logic [7:0] r_tx_data, w_tx_data_d;
  logic       r_new_tx, w_new_tx_d;

  logic       w_push, w_pop, w_bit;
  logic [7:0] w_char;

  assign o_in_ready    = (r_count != LP_DEPTH);
  assign o_overflow    = i_in_valid & ~o_in_ready;
  assign w_push        = i_in_valid & o_in_ready;
  assign w_pop         = (r_state == StIdle) && (r_count != '0);
  assign o_busy        = (r_state != StIdle) || (r_count != '0);
  assign o_fifo_count  = r_count;
  assign o_tx_data     = r_tx_data;
  assign o_new_tx_data = r_new_tx;

  // Storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= i_in_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + 1'b1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign w_bit = (MSB_FIRST != 0) ? r_shift[7] : r_shift[0];

  always_comb begin
    w_char = 8'h0A;
    if (r_idx < 4'd8) begin
      w_char = w_bit ? 8'h31 : 8'h30;
    end else if (r_idx == 4'd8) begin
      w_char = 8'h0D;
    end
  end

  always_comb begin
    w_state_d   = r_state;
    w_shift_d   = r_shift;
    w_idx_d     = r_idx;
    w_tx_data_d = r_tx_data;
    w_new_tx_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (r_count != '0) begin
          w_shift_d = r_mem[r_rptr];
          w_idx_d   = 4'd0;
          w_state_d = StSend;
        end
      end
      StSend: begin
        if (!i_tx_busy) begin
          w_new_tx_d  = 1'b1;
          w_tx_data_d = w_char;
          w_state_d   = StGap;
        end
      end
      StGap: begin
        // This cycle lets the UART raise busy before the next character is offered.
        w_shift_d = (MSB_FIRST != 0) ? {r_shift[6:0], 1'b0} : {1'b0, r_shift[7:1]};
        w_idx_d   = r_idx + 4'd1;
        w_state_d = (r_idx == LP_LAST) ? StIdle : StSend;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= StIdle;
      r_shift   <= '0;
      r_idx     <= '0;
      r_tx_data <= 8'h00;
      r_new_tx  <= 1'b0;
    end else begin
      r_state   <= w_state_d;
      r_shift   <= w_shift_d;
      r_idx     <= w_idx_d;
      r_tx_data <= w_tx_data_d;
      r_new_tx  <= w_new_tx_d;
    end
  end

endmodule

// File: tb/tb_bit_string_printer.sv
// Directed bench for bit_string_printer: two instances (CRLF/MSB-first and bits-only/LSB-first),
// a busy-counting UART model each, and per-instance character scoreboards.
module tb_bit_string_printer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic [7:0] a_in = 8'h00, b_in = 8'h00;
  logic       a_val = 1'b0, b_val = 1'b0;
  logic       a_ready, a_ovf, a_new, a_busy, a_txbusy;
  logic       b_ready, b_ovf, b_new, b_busy, b_txbusy;
  logic [7:0] a_tx, b_tx;
  logic [2:0] a_count, b_count;
  logic       force_a = 1'b0;

  int cnt_a = 0, cnt_b = 0;
  logic [7:0] qa[$], qb[$];
  int strobes_a = 0, strobes_b = 0;
  logic prev_a = 1'b0, prev_b = 1'b0;
  int n_chk = 0, n_fail = 0;

  always #5 clk = ~clk;

  bit_string_printer #(.FIFO_DEPTH(4), .ADDR_W(2), .SEND_CRLF(1), .MSB_FIRST(1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_data(a_in), .i_in_valid(a_val),
    .o_in_ready(a_ready), .o_overflow(a_ovf), .o_tx_data(a_tx), .o_new_tx_data(a_new),
    .i_tx_busy(a_txbusy), .o_busy(a_busy), .o_fifo_count(a_count)
  );

  bit_string_printer #(.FIFO_DEPTH(4), .ADDR_W(2), .SEND_CRLF(0), .MSB_FIRST(0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_in_data(b_in), .i_in_valid(b_val),
    .o_in_ready(b_ready), .o_overflow(b_ovf), .o_tx_data(b_tx), .o_new_tx_data(b_new),
    .i_tx_busy(b_txbusy), .o_busy(b_busy), .o_fifo_count(b_count)
  );

  // UART model: busy for 10 cycles after each strobe.
  always @(posedge clk) begin
    if (a_new) cnt_a <= 10;
    else if (cnt_a != 0) cnt_a <= cnt_a - 1;
    if (b_new) cnt_b <= 10;
    else if (cnt_b != 0) cnt_b <= cnt_b - 1;
  end
  assign a_txbusy = force_a | (cnt_a != 0);
  assign b_txbusy = (cnt_b != 0);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic exp_value(input logic [7:0] v, input bit crlf, input bit msb, input bit to_b);
    logic [7:0] c;
    for (int i = 0; i < 8; i++) begin
      c = (msb ? v[7-i] : v[i]) ? 8'h31 : 8'h30;
      if (to_b) qb.push_back(c); else qa.push_back(c);
    end
    if (crlf) begin
      if (to_b) begin qb.push_back(8'h0D); qb.push_back(8'h0A); end
      else begin qa.push_back(8'h0D); qa.push_back(8'h0A); end
    end
  endtask

  // Advance to the next falling edge and score any strobes seen there.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    if (a_new) begin
      strobes_a++;
      check("a_no_back_to_back", prev_a, 0);
      check("a_strobe_expected", qa.size() != 0, 1);
      if (qa.size() != 0) begin
        e = qa.pop_front();
        check("a_char", a_tx, e);
      end
    end
    if (b_new) begin
      strobes_b++;
      check("b_no_back_to_back", prev_b, 0);
      check("b_strobe_expected", qb.size() != 0, 1);
      if (qb.size() != 0) begin
        e = qb.pop_front();
        check("b_char", b_tx, e);
      end
    end
    prev_a = a_new;
    prev_b = b_new;
  endtask

  task automatic wait_drain(input string tag, input bit sel, input int budget);
    int k = 0;
    bit done = 1'b0;
    while (!done && k < budget) begin
      tick();
      k++;
      done = sel ? (qb.size() == 0 && !b_busy) : (qa.size() == 0 && !a_busy);
    end
    check(tag, done, 1);
  endtask

  initial begin
    int base, k;
    bit accepted;
    int cexp[6] = '{0, 1, 1, 2, 3, 4};

    // Reset state
    #12;
    check("rst_ready", a_ready, 1);
    check("rst_overflow", a_ovf, 0);
    check("rst_tx_data", a_tx, 8'h00);
    check("rst_new_tx", a_new, 0);
    check("rst_busy", a_busy, 0);
    check("rst_count", a_count, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // T1: single value A5 with the UART model pacing
    a_val = 1'b1; a_in = 8'hA5;
    #1 check("t1_ready", a_ready, 1);
    exp_value(8'hA5, 1, 1, 0);
    base = strobes_a;
    tick();
    a_val = 1'b0;
    wait_drain("t1_drain", 0, 500);
    check("t1_strobes", strobes_a - base, 10);

    // T2/T4: busy held, six pushes, sixth overflows, then a long busy hold
    force_a = 1'b1;
    base = strobes_a;
    for (int i = 0; i < 6; i++) begin
      tick();
      a_val = 1'b1;
      a_in = 8'(8'h11 * (i + 1));
      #1;
      check("t2_count", a_count, cexp[i]);
      check("t2_ready", a_ready, (i < 5) ? 1 : 0);
      check("t2_overflow", a_ovf, (i == 5) ? 1 : 0);
      if (i < 5) exp_value(a_in, 1, 1, 0);
    end
    tick();
    a_val = 1'b0;
    #1;
    check("t2_overflow_clear", a_ovf, 0);
    check("t2_count_full", a_count, 4);
    for (int i = 0; i < 100; i++) tick();
    check("t4_no_strobe", strobes_a - base, 0);
    check("t4_new_tx_low", a_new, 0);
    check("t4_busy", a_busy, 1);
    force_a = 1'b0;
    wait_drain("t2_drain", 0, 3000);
    check("t2_strobes", strobes_a - base, 50);

    // T6: pop at full occupancy, then refill the freed slot
    force_a = 1'b1;
    base = strobes_a;
    for (int i = 0; i < 5; i++) begin
      tick();
      a_val = 1'b1;
      a_in = 8'(8'hA0 + i);
      #1 check("t6_ready_fill", a_ready, 1);
      exp_value(a_in, 1, 1, 0);
    end
    tick();
    a_val = 1'b1;
    a_in = 8'h77;
    force_a = 1'b0;
    accepted = 1'b0;
    k = 0;
    while (!accepted && k < 2000) begin
      #1;
      if (a_ready) begin
        accepted = 1'b1;
        check("t6_count_before_refill", a_count, 3);
        exp_value(8'h77, 1, 1, 0);
      end else begin
        check("t6_full_count", a_count, 4);
        check("t6_full_overflow", a_ovf, 1);
      end
      tick();
      k++;
    end
    a_val = 1'b0;
    check("t6_accepted", accepted, 1);
    check("t6_count_after_refill", a_count, 4);
    wait_drain("t6_drain", 0, 4000);
    check("t6_strobes", strobes_a - base, 60);

    // T3: bits only, LSB first
    b_val = 1'b1; b_in = 8'h01;
    #1 check("t3_ready", b_ready, 1);
    exp_value(8'h01, 0, 0, 1);
    base = strobes_b;
    tick();
    b_val = 1'b0;
    wait_drain("t3_drain", 1, 500);
    check("t3_strobes", strobes_b - base, 8);

    // T5: asynchronous reset in the middle of a message
    a_val = 1'b1; a_in = 8'hF0;
    exp_value(8'hF0, 1, 1, 0);
    base = strobes_a;
    tick();
    a_val = 1'b0;
    k = 0;
    while (strobes_a - base < 3 && k < 300) begin
      tick();
      k++;
    end
    check("t5_third_char", strobes_a - base, 3);
    #1 rst_n = 1'b0;
    #1;
    check("t5_rst_tx_data", a_tx, 8'h00);
    check("t5_rst_new_tx", a_new, 0);
    check("t5_rst_busy", a_busy, 0);
    check("t5_rst_count", a_count, 0);
    check("t5_rst_ready", a_ready, 1);
    qa.delete();
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    a_val = 1'b1; a_in = 8'h0F;
    exp_value(8'h0F, 1, 1, 0);
    base = strobes_a;
    tick();
    a_val = 1'b0;
    wait_drain("t5_drain", 0, 500);
    check("t5_strobes", strobes_a - base, 10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
